muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide execution unit.
- Sits directly downstream of the main control FSM, in the execute stage of the multi-cycle datapath.
- The FSM issues a one-cycle start with an op code. The FSM waits in its execute state until done.
- The 64-bit result {result_hi, result_lo} feeds the ALUWB write-back, with RegWHi writing result_hi.

Parameters:
- WIDTH, 32: operand width. Results are 2*WIDTH, split into hi and lo halves.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; returns the unit to IDLE.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- op  input  2  00=UMUL, 01=SMUL, 10=UDIV, 11=SDIV; captured with start.
- a  input  WIDTH  multiplicand / dividend; captured with start.
- b  input  WIDTH  multiplier / divisor; captured with start.
- busy  output  1  high while the operation is in progress (RUN).
- done  output  1  one-cycle pulse; results valid from this cycle.
- result_lo  output  WIDTH  low product half / quotient.
- result_hi  output  WIDTH  high product half / remainder.
- div_by_zero  output  1  set with done when a divide had b==0; held with the results.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: state=IDLE. busy=0, done=0, result_lo=0, result_hi=0, div_by_zero=0, counter=0.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 -> capture op/a/b, load count=WIDTH, go to RUN. If a divide has b==0, go to DONE instead.
  - RUN: one iteration per cycle; count decrements. When the last iteration completes (count 1->0), go to DONE.
  - DONE: done=1 for exactly this cycle.
    - start=1 in DONE is accepted exactly as in IDLE (back-to-back issue).
    - Otherwise go to IDLE.
- Latency: start sampled at edge T. busy=1 for cycles T+1..T+WIDTH. done=1 in cycle T+WIDTH+1.
- Divide by zero: done in cycle T+1, busy never asserted.
- start while busy: ignored; the in-flight operation is unaffected.
- Outputs: result_lo/result_hi/div_by_zero update only on entry to DONE. They hold until the next DONE or reset.
- Multiply: shift-add, one multiplier bit per cycle, 2*WIDTH accumulator. result = a*b as a 2*WIDTH value.
- Divide: restoring algorithm, one quotient bit per cycle, WIDTH+1-bit partial remainder. lo=quotient, hi=remainder.
- Signed ops (SMUL/SDIV):
  - Operate on magnitudes.
  - Negate the product/quotient when the operand signs differ.
  - The remainder takes the sign of the dividend.
  - Magnitude of the most-negative value is taken as an unsigned WIDTH-bit value (2^(WIDTH-1)).
- SDIV most-negative / -1: quotient = most-negative value (wraps), remainder = 0, no flag.
- Divide by zero (b==0, UDIV or SDIV): lo = all ones, hi = a unmodified, div_by_zero=1.
- div_by_zero=0 for all multiplies and for non-zero divisors.
- Reset mid-operation: abort immediately to IDLE. No done pulse; outputs cleared to 0.
- start and reset in the same cycle: reset wins.

Decomposition:
- Shared package:
  - op encoding constants OP_UMUL/OP_SMUL/OP_UDIV/OP_SDIV.
  - state encoding MD_IDLE/MD_RUN/MD_DONE.
  - WIDTH default.
- The main control FSM imports the same op constants.
- One natural sub-module: muldiv_sign_fix.
  - Combinational.
  - Operand magnitude extraction and final conditional negation of the product/quotient/remainder.
  - Instanced for both input conditioning and output fixup.

Test Plan:
- UMUL a=0xFFFFFFFF b=0xFFFFFFFF, start at T -> busy T+1..T+32; done at T+33; hi=0xFFFFFFFE lo=0x00000001.
- SMUL a=-3 (0xFFFFFFFD) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB, div_by_zero=0.
- UDIV a=100 b=7 -> lo=14 hi=2.
- SDIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
- SDIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
- UDIV a=5 b=0 at T -> done at T+1, busy never 1; lo=0xFFFFFFFF hi=5, div_by_zero=1.
- Back-to-back and abort, UMUL 6*7:
  - start re-asserted at cycle T+10 -> ignored.
  - done at T+33 with lo=42.
  - start on the done cycle -> new op accepted.
  - reset at its T+5 -> IDLE next cycle, all outputs 0, no done.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit and the control FSM
// that issues operations to it.
package muldiv_pkg;
    localparam int MD_WIDTH = 32;

    localparam logic [1:0] OP_UMUL = 2'b00;
    localparam logic [1:0] OP_SMUL = 2'b01;
    localparam logic [1:0] OP_UDIV = 2'b10;
    localparam logic [1:0] OP_SDIV = 2'b11;

    typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_t;
endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation: takes operand magnitudes on the way in
// and restores the sign of product/quotient/remainder on the way out.
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);
    assign res = neg ? (~val + W'(1)) : val;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle,
// signed ops handled by magnitude arithmetic plus a final sign fixup.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    md_state_t          state, state_nxt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc, acc_nxt, fix_lo_in, fix_lo;
    logic [WIDTH-1:0]   rem, rem_nxt, fix_rem, mag_a, mag_b;
    logic [WIDTH:0]     part, msum;
    logic [CW-1:0]      cnt;
    logic               neg_q, neg_r, ge, accept, div_zero;

    assign accept   = start && (state != MD_RUN);
    assign div_zero = op[1] && (b == '0);
    assign busy     = (state == MD_RUN);
    assign done     = (state == MD_DONE);

    muldiv_sign_fix #(.W(WIDTH)) u_mag_a (.val(a), .neg(op[0] & a[WIDTH-1]), .res(mag_a));
    muldiv_sign_fix #(.W(WIDTH)) u_mag_b (.val(b), .neg(op[0] & b[WIDTH-1]), .res(mag_b));

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
    // Divide: acc low half shifts dividend bits out and quotient bits in; the
    // WIDTH+1-bit partial remainder always settles below the divisor, so WIDTH
    // bits of it are kept between iterations.
    always_comb begin
        part    = {rem, acc[WIDTH-1]};
        ge      = (part >= {1'b0, opnd});
        msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        acc_nxt = {msum, acc[WIDTH-1:1]};
        rem_nxt = rem;
        if (op_q[1]) begin
            rem_nxt = ge ? WIDTH'(part - {1'b0, opnd}) : part[WIDTH-1:0];
            acc_nxt = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ge};
        end
    end

    assign fix_lo_in = op_q[1] ? {{WIDTH{1'b0}}, acc_nxt[WIDTH-1:0]} : acc_nxt;

    muldiv_sign_fix #(.W(2*WIDTH)) u_fix_lo  (.val(fix_lo_in), .neg(neg_q), .res(fix_lo));
    muldiv_sign_fix #(.W(WIDTH))   u_fix_rem (.val(rem_nxt),   .neg(neg_r), .res(fix_rem));

    always_ff @(posedge clk) begin
        if (reset) state <= MD_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_RUN:  if (cnt == CW'(1)) state_nxt = MD_DONE;
            default: begin
                state_nxt = MD_IDLE;
                if (start) state_nxt = div_zero ? MD_DONE : MD_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q        <= '0;
            opnd        <= '0;
            acc         <= '0;
            rem         <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            result_lo   <= '0;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            op_q  <= op;
            opnd  <= op[1] ? mag_b : mag_a;
            acc   <= {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
            rem   <= '0;
            cnt   <= CW'(WIDTH);
            neg_q <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= op[0] & op[1] & a[WIDTH-1];
            if (div_zero) begin
                result_lo   <= '1;
                result_hi   <= a;
                div_by_zero <= 1'b1;
            end
        end else if (state == MD_RUN) begin
            acc <= acc_nxt;
            rem <= rem_nxt;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                result_lo   <= fix_lo[WIDTH-1:0];
                result_hi   <= op_q[1] ? fix_rem : fix_lo[2*WIDTH-1:WIDTH];
                div_by_zero <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expectations pushed at issue, popped on done.
module tb_muldiv_unit;
    import muldiv_pkg::*;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, div_by_zero;
    logic [W-1:0] result_lo, result_hi;

    typedef struct packed {logic [W-1:0] lo; logic [W-1:0] hi; logic dbz;} exp_t;
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        logic [63:0] p;
        longint      sx, sy, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.dbz = 1'b0;
        case (o)
            OP_UMUL: begin p = {32'b0, x} * {32'b0, y}; e.lo = p[31:0]; e.hi = p[63:32]; end
            OP_SMUL: begin p = sx * sy;                 e.lo = p[31:0]; e.hi = p[63:32]; end
            default: begin
                if (y == 0) begin
                    e.lo = '1; e.hi = x; e.dbz = 1'b1;
                end else if (o == OP_UDIV) begin
                    e.lo = x / y; e.hi = x % y;
                end else begin
                    q = sx / sy; r = sx % sy;
                    e.lo = q[31:0]; e.hi = r[31:0];
                end
            end
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (sb.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                chk("result_lo", result_lo, e.lo);
                chk("result_hi", result_hi, e.hi);
                chk("div_by_zero", div_by_zero, e.dbz);
            end
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int lat, bc;
        bit dz;
        dz = o[1] && (y == 0);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        sb.push_back(model(o, x, y));
        lat = 0; bc = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) bc++;
        end while (!done && lat < 200);
        chk("latency", lat, dz ? 1 : W + 1);
        chk("busy_cycles", bc, dz ? 0 : W);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int lat, bc;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_lo", result_lo, 0);
        chk("rst_hi", result_hi, 0);
        chk("rst_dbz", div_by_zero, 0);
        reset = 1'b0;

        run_op(OP_UMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(OP_SMUL, 32'hFFFF_FFFD, 32'd7);
        run_op(OP_UDIV, 32'd100, 32'd7);
        run_op(OP_SDIV, 32'hFFFF_FFF9, 32'd2);
        run_op(OP_SDIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(OP_UDIV, 32'd5, 32'd0);
        run_op(OP_SDIV, 32'h8000_0000, 32'd0);
        run_op(OP_SMUL, 32'h8000_0000, 32'h8000_0000);
        run_op(OP_SDIV, 32'd7, 32'hFFFF_FFFE);
        for (int i = 0; i < 8; i++)
            run_op(2'(i % 4), $urandom, (i % 4 >= 2) ? $urandom_range(1, 1000) : $urandom);

        // in-flight op ignores a second start, then back-to-back issue from DONE
        @(negedge clk);
        start = 1'b1; op = OP_UMUL; a = 32'd6; b = 32'd7;
        sb.push_back(model(OP_UMUL, 32'd6, 32'd7));
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            start = (lat == 9);
            if (lat == 9) begin a = 32'd1; b = 32'd1; end
        end while (!done && lat < 200);
        chk("b2b_latency", lat, W + 1);
        start = 1'b1; op = OP_UMUL; a = 32'd6; b = 32'd7;
        sb.push_back(model(OP_UMUL, 32'd6, 32'd7));
        bc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) bc++;
        end
        chk("b2b_busy", bc, 4);
        reset = 1'b1;
        @(negedge clk);
        void'(sb.pop_back());
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_lo", result_lo, 0);
        chk("abort_hi", result_hi, 0);
        chk("abort_dbz", div_by_zero, 0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
